ibex_rf_wr_arbiter: RTL



---
 rtl/ibex_rf_wr_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ibex_rf_wr_arbiter.sv
// Register-file write-port arbiter between EX results and LSU load data.
// Latency: LSU and an uncontested EX write reach the RF in the same cycle.
// A deferred EX write waits in an in-order queue and drains when the port is free.
// Backpressure: LSU is never stalled. ex_ready_o drops only while the EX queue is full.
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   ex_valid_i/ex_ready_o/ex_waddr_i/ex_wdata_i     EX write request handshake
//   lsu_valid_i/lsu_waddr_i/lsu_wdata_i  LSU load writeback (no back-pressure)
//   rf_we_o/rf_waddr_o/rf_wdata_o        register-file write port
//   raddr_a_i/raddr_b_i -> hazard_a_o/hazard_b_o   ID reads vs. queued EX entries
//   pending_cnt_o, conflict_o            queue occupancy, EX-deferred pulse
module ibex_rf_wr_arbiter #(
   parameter int Depth     = 2,
   parameter int DataWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 ex_valid_i,
   output logic                 ex_ready_o,
   input  logic [4:0]           ex_waddr_i,
   input  logic [DataWidth-1:0] ex_wdata_i,
   input  logic                 lsu_valid_i,
   input  logic [4:0]           lsu_waddr_i,
   input  logic [DataWidth-1:0] lsu_wdata_i,
   output logic                 rf_we_o,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   input  logic [4:0]           raddr_a_i,
   input  logic [4:0]           raddr_b_i,
   output logic                 hazard_a_o,
   output logic                 hazard_b_o,
   output logic [2:0]           pending_cnt_o,
   output logic                 conflict_o
);

   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   // Queue storage; q_vld marks live entries so the hazard check needs no
   // pointer arithmetic.
   logic [4:0]           q_addr [Depth];
   logic [DataWidth-1:0] q_data [Depth];
   logic [Depth-1:0]     q_vld;
   logic [PtrW-1:0]      wr_ptr;
   logic [PtrW-1:0]      rd_ptr;
   logic [2:0]           cnt;

   logic lsu_win;
   logic q_nonempty;
   logic ex_acc_nz;
   logic pop;
   logic bypass;
   logic push;
   logic hit_a;
   logic hit_b;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // A full queue refuses EX even when its head pops this cycle.
   assign ex_ready_o = !rst_i && (cnt < 3'(Depth));

   // A write to x0 is accepted and then dropped.
   assign ex_acc_nz  = ex_valid_i && ex_ready_o && (ex_waddr_i != 5'd0);
   // An LSU write to x0 leaves the port free.
   assign lsu_win    = !rst_i && lsu_valid_i && (lsu_waddr_i != 5'd0);
   assign q_nonempty = (cnt != 3'd0);
   assign pop        = !rst_i && !lsu_win && q_nonempty;
   // Bypass is allowed only when the queue is empty, which keeps EX in order.
   assign bypass     = !lsu_win && !q_nonempty && ex_acc_nz;
   assign push       = ex_acc_nz && !bypass;
   assign conflict_o = push;

   assign pending_cnt_o = rst_i ? 3'd0 : cnt;

   always_comb begin
      rf_we_o    = 1'b0;
      rf_waddr_o = '0;
      rf_wdata_o = '0;
      if (lsu_win) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = lsu_waddr_i;
         rf_wdata_o = lsu_wdata_i;
      end else if (pop) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = q_addr[rd_ptr];
         rf_wdata_o = q_data[rd_ptr];
      end else if (bypass) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = ex_waddr_i;
         rf_wdata_o = ex_wdata_i;
      end
   end

   // The hazard check uses registered entries only. The head being popped
   // still flags, and the bypass path never flags.
   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      for (int i = 0; i < Depth; i++) begin
         if (q_vld[i] && (q_addr[i] == raddr_a_i)) hit_a = 1'b1;
         if (q_vld[i] && (q_addr[i] == raddr_b_i)) hit_b = 1'b1;
      end
   end

   assign hazard_a_o = !rst_i && (raddr_a_i != 5'd0) && hit_a;
   assign hazard_b_o = !rst_i && (raddr_b_i != 5'd0) && hit_b;

   // Push and pop never target the same slot in one cycle.
   // The queue is either empty, so no pop happens, or full, so no push happens.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt    <= 3'd0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         q_vld  <= '0;
      end else begin
         if (push) begin
            q_vld[wr_ptr] <= 1'b1;
            wr_ptr        <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            q_vld[rd_ptr] <= 1'b0;
            rd_ptr        <= ptr_inc(rd_ptr);
         end
         if (push && !pop) begin
            cnt <= cnt + 3'd1;
         end else if (pop && !push) begin
            cnt <= cnt - 3'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         q_addr[wr_ptr] <= ex_waddr_i;
         q_data[wr_ptr] <= ex_wdata_i;
      end
   end

endmodule
